// File: rtl/iq_free_list_pkg.sv
// iq_free_list_pkg
//   Shared issue-queue configuration for the free-list slice: queue geometry,
//   port widths and the freed-entry packet carried from the free-issue-queue
//   stage into the free list.
package iq_free_list_pkg;

  localparam int SIZE_ISSUEQ     = 32;
  localparam int SIZE_ISSUEQ_LOG = 5;
  localparam int ISSUE_WIDTH     = 4;
  localparam int DISPATCH_WIDTH  = 4;

  // One released issue-queue entry.
  typedef struct packed {
    logic                       valid;
    logic [SIZE_ISSUEQ_LOG-1:0] id;
  } iqEntryPkt;

endpackage

// File: rtl/iq_free_compact.sv
// iq_free_compact
//   Packs the valid freed-entry slots in port order (lowest port first) so the
//   free list can write them to consecutive tail positions.
//   Ports:
//     freedEntry  in   freed-entry packets, one per issue port
//     compId      out  compacted ids; slot k holds the k-th valid id
//                      (slots at or above validCount read as zero)
//     validCount  out  number of valid packets this cycle (0..NUM_PORTS)
module iq_free_compact
  import iq_free_list_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 6
) (
  input  iqEntryPkt                  freedEntry [0:NUM_PORTS-1],
  output logic [SIZE_ISSUEQ_LOG-1:0] compId     [0:NUM_PORTS-1],
  output logic [CNT_W-1:0]           validCount
);

  always_comb begin
    int unsigned cnt;
    int unsigned pos [0:NUM_PORTS-1];
    cnt = 0;
    // pos[i] is the output slot port i lands in if it is valid.
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      pos[i] = cnt;
      if (freedEntry[i].valid) cnt = cnt + 1;
    end
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      compId[k] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (freedEntry[i].valid && (pos[i] == k)) compId[k] = freedEntry[i].id;
      end
    end
    validCount = CNT_W'(cnt);
  end

endmodule

// File: rtl/iq_free_list.sv
// iq_free_list
//   Circular free list of issue-queue entry ids. Dispatch takes DISPATCH_WIDTH
//   ids at a time from the head (all or nothing); freed entries are compacted
//   and appended at the tail. Pointers wrap modulo SIZE_ISSUEQ, which need not
//   be a power of two.
//   Ports:
//     clk              clock, rising edge
//     reset            asynchronous active-low reset
//     freedEntry_i     freed entries from the free-issue-queue stage
//     dispatchReady_i  dispatch wants a DISPATCH_WIDTH allocation
//     flush_i          recovery: return to the all-free state
//     freeEntry_o      next DISPATCH_WIDTH free ids, oldest first
//     freeCount_o      ids currently held in the list
//     iqFull_o         fewer than DISPATCH_WIDTH ids held; dispatch stalls
//     freeListError_o  sticky consistency-checker flag
//   Build option: define IQ_FREELIST_CHECK_EN to add the in-list shadow vector
//   and checker; otherwise freeListError_o is tied low.
//   The freed-entry packet id width comes from iq_free_list_pkg, so
//   SIZE_ISSUEQ_LOG must match the package value.
module iq_free_list
  import iq_free_list_pkg::*;
#(
  parameter int SIZE_ISSUEQ     = iq_free_list_pkg::SIZE_ISSUEQ,
  parameter int SIZE_ISSUEQ_LOG = iq_free_list_pkg::SIZE_ISSUEQ_LOG,
  parameter int ISSUE_WIDTH     = iq_free_list_pkg::ISSUE_WIDTH,
  parameter int DISPATCH_WIDTH  = iq_free_list_pkg::DISPATCH_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  iqEntryPkt                  freedEntry_i [0:ISSUE_WIDTH-1],
  input  logic                       dispatchReady_i,
  input  logic                       flush_i,
  output logic [SIZE_ISSUEQ_LOG-1:0] freeEntry_o  [0:DISPATCH_WIDTH-1],
  output logic [SIZE_ISSUEQ_LOG:0]   freeCount_o,
  output logic                       iqFull_o,
  output logic                       freeListError_o
);

  localparam int              PW     = SIZE_ISSUEQ_LOG + 1;
  localparam logic [PW-1:0]   SIZE_C = PW'(SIZE_ISSUEQ);
  localparam logic [PW-1:0]   DW_C   = PW'(DISPATCH_WIDTH);

  logic [SIZE_ISSUEQ_LOG-1:0] list [0:SIZE_ISSUEQ-1];
  logic [SIZE_ISSUEQ_LOG-1:0] head, tail, headNext, tailNext;
  logic [PW-1:0]              count, countNext;
  logic [PW-1:0]              popAmt, space, accepted, pushCount;
  logic [SIZE_ISSUEQ_LOG-1:0] compId [0:ISSUE_WIDTH-1];
  logic                       pop;

  // Add at PW bits, then fold back once; inc never exceeds SIZE_ISSUEQ.
  function automatic logic [SIZE_ISSUEQ_LOG-1:0] wrapAdd(
    input logic [SIZE_ISSUEQ_LOG-1:0] ptr,
    input logic [PW-1:0]              inc
  );
    logic [PW-1:0] sum;
    sum = {1'b0, ptr} + inc;
    if (sum >= SIZE_C) sum = sum - SIZE_C;
    return sum[SIZE_ISSUEQ_LOG-1:0];
  endfunction

  iq_free_compact #(
    .NUM_PORTS (ISSUE_WIDTH),
    .CNT_W     (PW)
  ) u_compact (
    .freedEntry (freedEntry_i),
    .compId     (compId),
    .validCount (pushCount)
  );

  assign iqFull_o    = (count < DW_C);
  assign freeCount_o = count;
  assign pop         = dispatchReady_i & ~iqFull_o;

  always_comb begin
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      freeEntry_o[k] = list[wrapAdd(head, PW'(k))];
    end
  end

  // Pushes beyond the room left after this cycle's pop are dropped.
  always_comb begin
    popAmt    = pop ? DW_C : '0;
    space     = SIZE_C - (count - popAmt);
    accepted  = (pushCount > space) ? space : pushCount;
    countNext = count - popAmt + accepted;
    headNext  = pop ? wrapAdd(head, DW_C) : head;
    tailNext  = wrapAdd(tail, accepted);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) list[i] <= SIZE_ISSUEQ_LOG'(i);
      head  <= '0;
      tail  <= '0;
      count <= SIZE_C;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < SIZE_ISSUEQ; i++) list[i] <= SIZE_ISSUEQ_LOG'(i);
      head  <= '0;
      tail  <= '0;
      count <= SIZE_C;
    end else begin
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        if (PW'(k) < accepted) list[wrapAdd(tail, PW'(k))] <= compId[k];
      end
      head  <= headNext;
      tail  <= tailNext;
      count <= countNext;
    end
  end

`ifdef IQ_FREELIST_CHECK_EN
  logic [SIZE_ISSUEQ-1:0] inList, inListNext;
  logic                   errSticky, errNow;

  // Ids popped this cycle leave the shadow before the push is checked.
  always_comb begin
    logic [SIZE_ISSUEQ-1:0] kept;
    kept   = inList;
    errNow = 1'b0;
    if (pop) begin
      for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) kept[freeEntry_o[k]] = 1'b0;
    end
    inListNext = kept;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      if (PW'(k) < pushCount) begin
        if (kept[compId[k]]) errNow = 1'b1;
        for (int unsigned j = 0; j < k; j++) begin
          if (compId[j] == compId[k]) errNow = 1'b1;
        end
        if (PW'(k) < accepted) inListNext[compId[k]] = 1'b1;
      end
    end
    if (pushCount > space) errNow = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inList    <= '1;
      errSticky <= 1'b0;
    end else if (flush_i) begin
      inList    <= '1;
      errSticky <= 1'b0;
    end else begin
      inList    <= inListNext;
      errSticky <= errSticky | errNow;
    end
  end

  assign freeListError_o = errSticky;
`else
  assign freeListError_o = 1'b0;
`endif

endmodule

// File: tb/tb_iq_free_list.sv
// tb_iq_free_list
//   Directed bench for iq_free_list at SIZE_ISSUEQ=32, ISSUE_WIDTH=4,
//   DISPATCH_WIDTH=4, with hand-computed expected values.
module tb_iq_free_list;
  import iq_free_list_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  iqEntryPkt  freedEntry [0:3];
  logic       dispatchReady;
  logic       flush;
  logic [4:0] freeEntry [0:3];
  logic [5:0] freeCount;
  logic       iqFull;
  logic       freeListError;

  int nChecks = 0;
  int nBad    = 0;

  int ids [0:19] = '{16, 17, 18, 19, 20, 21, 22, 23, 24, 25,
                     26, 27, 28, 29, 30, 31, 0, 1, 2, 3};

  iq_free_list #(
    .SIZE_ISSUEQ     (32),
    .SIZE_ISSUEQ_LOG (5),
    .ISSUE_WIDTH     (4),
    .DISPATCH_WIDTH  (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .freedEntry_i    (freedEntry),
    .dispatchReady_i (dispatchReady),
    .flush_i         (flush),
    .freeEntry_o     (freeEntry),
    .freeCount_o     (freeCount),
    .iqFull_o        (iqFull),
    .freeListError_o (freeListError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs != exp) begin
      nBad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chkWin(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "[0]"}, int'(freeEntry[0]), e0);
    chk({tag, "[1]"}, int'(freeEntry[1]), e1);
    chk({tag, "[2]"}, int'(freeEntry[2]), e2);
    chk({tag, "[3]"}, int'(freeEntry[3]), e3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearPush();
    for (int i = 0; i < 4; i++) freedEntry[i] = '0;
  endtask

  task automatic setPort(input int p, input int id);
    freedEntry[p].valid = 1'b1;
    freedEntry[p].id    = 5'(id);
  endtask

  initial begin
    reset         = 1'b0;
    dispatchReady = 1'b0;
    flush         = 1'b0;
    clearPush();

    // During reset
    repeat (2) @(posedge clk);
    #1;
    chk("rstCount", int'(freeCount), 32);
    chk("rstFull", int'(iqFull), 0);
    chk("rstErr", int'(freeListError), 0);
    chkWin("rstWin", 0, 1, 2, 3);

    reset = 1'b1;
    step();
    chk("relCount", int'(freeCount), 32);

    // Drain the whole list four ids at a time
    for (int c = 0; c < 8; c++) begin
      chkWin("drain", 4*c, 4*c+1, 4*c+2, 4*c+3);
      chk("drainFull", int'(iqFull), 0);
      chk("drainCount", int'(freeCount), 32 - 4*c);
      dispatchReady = 1'b1;
      step();
    end
    dispatchReady = 1'b0;
    chk("emptyCount", int'(freeCount), 0);
    chk("emptyFull", int'(iqFull), 1);

    // Sparse push on ports 1 and 3
    setPort(1, 9);
    setPort(3, 5);
    step();
    clearPush();
    chk("sparseCount", int'(freeCount), 2);
    chk("sparseFull", int'(iqFull), 1);
    chk("sparse0", int'(freeEntry[0]), 9);
    chk("sparse1", int'(freeEntry[1]), 5);

    setPort(0, 20);
    setPort(2, 21);
    step();
    clearPush();
    chk("fourCount", int'(freeCount), 4);
    chk("fourFull", int'(iqFull), 0);
    chkWin("fourWin", 9, 5, 20, 21);

    for (int p = 0; p < 4; p++) setPort(p, 10 + p);
    step();
    clearPush();
    chk("eightCount", int'(freeCount), 8);

    // Pop and 2-entry push together: 8 - 4 + 2
    dispatchReady = 1'b1;
    setPort(0, 14);
    setPort(1, 15);
    step();
    dispatchReady = 1'b0;
    clearPush();
    chk("popPushCount", int'(freeCount), 6);
    chkWin("popPushWin", 10, 11, 12, 13);

    // Steady push4+pop4 moves tail 10 -> 30 and head 4 -> 24
    for (int c = 0; c < 5; c++) begin
      for (int p = 0; p < 4; p++) setPort(p, ids[4*c+p]);
      dispatchReady = 1'b1;
      step();
    end
    clearPush();
    dispatchReady = 1'b0;
    chk("steadyCount", int'(freeCount), 6);
    chkWin("steadyWin", 30, 31, 0, 1);

    // Count and tail stay congruent mod 4 here, so the stalled wrap case
    // uses count=2 with tail=30.
    dispatchReady = 1'b1;
    step();
    dispatchReady = 1'b0;
    chk("lowCount", int'(freeCount), 2);
    chk("lowFull", int'(iqFull), 1);
    chk("low0", int'(freeEntry[0]), 2);
    chk("low1", int'(freeEntry[1]), 3);

    for (int p = 0; p < 4; p++) setPort(p, 4 + p);
    dispatchReady = 1'b1;
    step();
    dispatchReady = 1'b0;
    clearPush();
    chk("stallCount", int'(freeCount), 6);
    chk("stallFull", int'(iqFull), 0);
    chkWin("stallWin", 2, 3, 4, 5);

    // Head wraps 28 -> 0; ids 6,7 sit at positions 0,1 after the tail wrap
    dispatchReady = 1'b1;
    step();
    dispatchReady = 1'b0;
    chk("wrapCount", int'(freeCount), 2);
    chk("wrap0", int'(freeEntry[0]), 6);
    chk("wrap1", int'(freeEntry[1]), 7);

    setPort(2, 8);
    step();
    clearPush();
    chk("tail2Count", int'(freeCount), 3);
    chk("tail2Id", int'(freeEntry[2]), 8);
    chk("errClean", int'(freeListError), 0);

    // Flush beats a simultaneous push and pop
    flush         = 1'b1;
    dispatchReady = 1'b1;
    setPort(0, 9);
    step();
    flush         = 1'b0;
    dispatchReady = 1'b0;
    clearPush();
    chk("flushCount", int'(freeCount), 32);
    chk("flushFull", int'(iqFull), 0);
    chk("flushErr", int'(freeListError), 0);
    chkWin("flushWin", 0, 1, 2, 3);

    dispatchReady = 1'b1;
    step();
    dispatchReady = 1'b0;
    chk("postFlushCount", int'(freeCount), 28);
    chkWin("postFlushWin", 4, 5, 6, 7);

    // Push an id that is still in the list
    setPort(0, 10);
    step();
    clearPush();
    chk("dupCount", int'(freeCount), 29);
`ifdef IQ_FREELIST_CHECK_EN
    chk("dupErr", int'(freeListError), 1);
    step();
    chk("dupErrHold", int'(freeListError), 1);
`else
    chk("dupErr", int'(freeListError), 0);
    step();
    chk("dupErrHold", int'(freeListError), 0);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushErrClr", int'(freeListError), 0);
    chk("flushCount2", int'(freeCount), 32);

    // Overflow push at full capacity is dropped
    setPort(0, 0);
    setPort(1, 1);
    step();
    clearPush();
    chk("ovfCount", int'(freeCount), 32);
    chk("ovfFull", int'(iqFull), 0);
`ifdef IQ_FREELIST_CHECK_EN
    chk("ovfErr", int'(freeListError), 1);
`else
    chk("ovfErr", int'(freeListError), 0);
`endif

    // Asynchronous reset between clock edges
    dispatchReady = 1'b1;
    step();
    dispatchReady = 1'b0;
    chk("preRstCount", int'(freeCount), 28);
    #2;
    reset = 1'b0;
    #1;
    chk("asyncCount", int'(freeCount), 32);
    chk("asyncErr", int'(freeListError), 0);
    chkWin("asyncWin", 0, 1, 2, 3);
    step();
    reset = 1'b1;
    step();
    chk("finalCount", int'(freeCount), 32);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
